fa4_bist: RTL and testbench
===========================

# fa4_bist

Built-in self-test sequencer and response checker for the 4-bit full-adder family. It drives every combination of `a`, `b` and `cin` into an adder under test, samples `s`/`cout`, and compares them against a behavioural sum. It also counts mismatches and captures the first failing vector. It sits beside an adder instance in silicon or FPGA and replaces the exhaustive simulation bench with a synthesizable pass/fail result.

## Interface
Parameters:
- `WIDTH`, default 4: operand width of the adder under test.
- `ERR_W`, default 10: width of the error counter. It saturates at 2^ERR_W−1.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: pulse or level. Sampled only in IDLE or DONE.
- `a_o` output WIDTH: operand A to the DUT.
- `b_o` output WIDTH: operand B to the DUT.
- `cin_o` output 1: carry-in to the DUT.
- `s_i` input WIDTH: DUT sum, treated as combinational from `a_o`/`b_o`/`cin_o`.
- `cout_i` input 1: DUT carry-out.
- `busy` output 1: high while the sweep runs.
- `done` output 1: high from sweep completion until the next start or reset.
- `pass` output 1: valid when `done`=1. High iff `err_cnt`==0.
- `err_cnt` output ERR_W: mismatch count, saturating.
- `fail_valid` output 1: high once the first mismatch is captured.
- `fail_a` output WIDTH: A of the first mismatching vector.
- `fail_b` output WIDTH: B of the first mismatching vector.
- `fail_cin` output 1: cin of the first mismatching vector.

## Operation
- Vector index `v` = {a, b, cin}, with 2·WIDTH+1 bits and N = 2^(2·WIDTH+1) vectors (512 for WIDTH=4).
- `v` counts 0 → N−1, so cin toggles fastest, then b, then a.
- Expected result = a + b + cin, computed at WIDTH+1 bits with no truncation. It is compared against {`cout_i`, `s_i`}.
- States:
  - IDLE: outputs at reset values. `start`=1 → DRIVE, clearing `v`, `err_cnt`, the fail fields, `done` and `pass`.
  - DRIVE: apply vector `v` on `a_o`/`b_o`/`cin_o` for one settle cycle, then go to CHECK.
  - CHECK: compare. On mismatch, `err_cnt`+1 (held at max if saturated). On mismatch while `fail_valid`=0, capture a/b/cin and set `fail_valid`.
  - CHECK exit: if `v`==N−1 → DONE, otherwise `v`+1 → DRIVE.
  - DONE: `busy`=0 and `done`=1. `pass` = (final `err_cnt`==0), including the last vector's result. `err_cnt` and the fail fields are held. `a_o`/`b_o`/`cin_o` return to 0. `start`=1 → restart exactly as from IDLE.
- `start` in DRIVE or CHECK is ignored.
- The DUT inputs are driven only from registers, so the stimulus has no glitches.

## Timing
- Reset values: all outputs 0, state IDLE. This applies immediately on `rst_n` falling, independent of `clk`.
- Reset mid-sweep aborts the sweep with no partial result retained. After `rst_n` rises, the block waits in IDLE for `start`.
- The edge that samples `start`=1 in IDLE/DONE sets `busy`=1 and `a_o`=`b_o`=`cin_o`=0 (vector 0).
- Each vector takes 2 cycles: DRIVE then CHECK. `s_i`/`cout_i` must settle within one clock period of the vector change.
- Comparison uses `s_i`/`cout_i` as sampled at the CHECK→next edge.
- Latency: `done` rises exactly 2·N cycles after the start edge (1024 cycles for WIDTH=4).
  - `busy` falls on the same edge.
  - `err_cnt` and `pass` are final on that edge.
- Last-vector mismatch: counted and reflected in `pass` on the same edge as `done` rises.
- Saturation: at 2^ERR_W−1 the counter holds. Further mismatches do not wrap, and `pass` stays 0.

## Test plan
- Correct behavioural adder, WIDTH=4: after start, `done`=1 exactly 1024 cycles later. Expect `pass`=1, `err_cnt`=0, `fail_valid`=0.
- `s[0]` stuck-at-0 DUT: expect `err_cnt`=256, `pass`=0, and first fail a=0, b=0, cin=1.
- `cout` stuck-at-0 DUT: expect `err_cnt`=256 (120 with cin=0 plus 136 with cin=1), and first fail a=0, b=15, cin=1.
- ERR_W=4 with the DUT outputs inverted: expect `err_cnt`=15 (saturated), `pass`=0, first fail a=0, b=0, cin=0.
- Reset and start interaction:
  - Assert `rst_n`=0 at cycle 300 of a sweep → all outputs 0 immediately.
  - Restart → full 1024-cycle sweep with correct results.
  - A `start` pulse during `busy` causes no change.
- Restart from DONE after a failing run with a correct DUT: counters and fail fields clear on the start edge, ending with `pass`=1.

Source files
------------

// File: rtl/fa4_bist.sv
`default_nettype none
// ============================================================================
// Module   : fa4_bist
// Purpose  : Built-in self-test sequencer and response checker for an
//            N-bit ripple/behavioural full adder. Sweeps every {a, b, cin}
//            combination, compares {cout, s} against a behavioural sum,
//            counts mismatches (saturating) and captures the first failure.
// Revision : 1.0  initial release
// ============================================================================
module fa4_bist #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             cin_o,
  input  logic [WIDTH-1:0] s_i,
  input  logic             cout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin
);

  // Vector index layout is {a, b, cin}: cin toggles fastest, then b, then a.
  localparam int VEC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [VEC_W-1:0] vec;
  logic             clear;
  logic             check;
  logic             last;
  logic [WIDTH:0]   expected;
  logic [WIDTH:0]   observed;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;

  // The DUT operands are plain bit-slices of the vector register, so the
  // stimulus is glitch-free. The index wraps to zero after the last vector,
  // which returns the operands to 0 in DONE without extra logic.
  assign a_o   = vec[VEC_W-1 -: WIDTH];
  assign b_o   = vec[WIDTH:1];
  assign cin_o = vec[0];

  assign last     = &vec;
  assign expected = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, cin_o};
  assign observed = {cout_i, s_i};
  assign mismatch = (observed != expected);

  // Saturating increment: the counter sticks at all-ones.
  assign err_nxt = (mismatch && (err_cnt != {ERR_W{1'b1}})) ?
                   err_cnt + ERR_W'(1) : err_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    check     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DRIVE;
          clear     = 1'b1;
        end
      end
      DRIVE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        check     = 1'b1;
        state_nxt = last ? DONE : DRIVE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sweep datapath: vector index, status flags, error count, first-fail capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
    end else if (clear) begin
      vec        <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
    end else if (check) begin
      vec     <= vec + VEC_W'(1);
      err_cnt <= err_nxt;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_a     <= a_o;
        fail_b     <= b_o;
        fail_cin   <= cin_o;
      end
      // The last vector's own result is folded into pass via err_nxt.
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_nxt == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fa4_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_fa4_bist
// Purpose  : Self-checking bench for fa4_bist. A reference adder with
//            selectable faults feeds the checker; expected sweep results are
//            queued at start and compared when done rises.
// Revision : 1.0  initial release
// ============================================================================
module tb_fa4_bist;

  localparam int WIDTH  = 4;
  localparam int N_VEC  = 1 << (2 * WIDTH + 1);
  localparam int LAT    = 2 * N_VEC;

  typedef struct {
    int          err;
    logic        pass;
    logic        fv;
    logic [3:0]  fa;
    logic [3:0]  fb;
    logic        fc;
  } exp_t;

  exp_t sb[$];

  logic clk;
  logic rst_n;
  logic start1;
  logic start4;
  int   mode;
  logic sel;

  int n_checks;
  int n_pass;

  // Main instance, default parameters.
  logic [3:0] a1, b1, s1, fa1, fb1;
  logic       cin1, cout1, busy1, done1, pass1, fv1, fc1;
  logic [9:0] err1;

  // Narrow-counter instance for saturation, fed by an inverting adder.
  logic [3:0] a4, b4, s4, fa4, fb4;
  logic       cin4, cout4, busy4, done4, pass4, fv4, fc4;
  logic [3:0] err4;

  fa4_bist #(.WIDTH(4), .ERR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a_o(a1), .b_o(b1), .cin_o(cin1), .s_i(s1), .cout_i(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_cin(fc1)
  );

  fa4_bist #(.WIDTH(4), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a_o(a4), .b_o(b4), .cin_o(cin4), .s_i(s4), .cout_i(cout4),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
    .fail_valid(fv4), .fail_a(fa4), .fail_b(fb4), .fail_cin(fc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test: correct sum with an optional injected fault.
  // 1: s[0] stuck-at-0, 2: cout stuck-at-0, 3: all outputs inverted.
  function automatic logic [4:0] faulty(input int md, input logic [4:0] sum);
    case (md)
      1:       return sum & 5'h1E;
      2:       return sum & 5'h0F;
      3:       return ~sum;
      default: return sum;
    endcase
  endfunction

  logic [4:0] r1, r4;
  always_comb begin
    r1 = faulty(mode, {1'b0, a1} + {1'b0, b1} + {4'b0, cin1});
    r4 = faulty(3, {1'b0, a4} + {1'b0, b4} + {4'b0, cin4});
  end
  assign s1    = r1[3:0];
  assign cout1 = r1[4];
  assign s4    = r4[3:0];
  assign cout4 = r4[4];

  // Selected-instance view used by the sweep task.
  logic        m_busy, m_done, m_pass, m_fv, m_fc;
  logic [3:0]  m_fa, m_fb;
  logic [8:0]  m_vec;
  logic [31:0] m_err;
  assign m_busy = sel ? busy4 : busy1;
  assign m_done = sel ? done4 : done1;
  assign m_pass = sel ? pass4 : pass1;
  assign m_fv   = sel ? fv4   : fv1;
  assign m_fc   = sel ? fc4   : fc1;
  assign m_fa   = sel ? fa4   : fa1;
  assign m_fb   = sel ? fb4   : fb1;
  assign m_vec  = sel ? {a4, b4, cin4} : {a1, b1, cin1};
  assign m_err  = sel ? {28'b0, err4} : {22'b0, err1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exhaustive reference of what a sweep over the given fault should report.
  task automatic push_expected(input int md, input int max_err);
    exp_t e;
    logic [4:0] want, got;
    e = '{err: 0, pass: 1'b0, fv: 1'b0, fa: 4'd0, fb: 4'd0, fc: 1'b0};
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          want = 5'(a + b + c);
          got  = faulty(md, want);
          if (got != want) begin
            if (e.err < max_err) e.err++;
            if (!e.fv) begin
              e.fv = 1'b1;
              e.fa = 4'(a);
              e.fb = 4'(b);
              e.fc = 1'(c);
            end
          end
        end
      end
    end
    e.pass = (e.err == 0);
    sb.push_back(e);
  endtask

  // One complete sweep on the selected instance, optionally with a stray
  // start pulse while busy.
  task automatic run_sweep(input logic use4, input int md, input logic poke);
    int   cycles;
    exp_t e;
    sel  = use4;
    mode = md;
    push_expected(use4 ? 3 : md, use4 ? 15 : 1023);
    @(negedge clk);
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    check("start_busy", {31'b0, m_busy}, 32'd1);
    check("start_clear", {m_vec, m_done, m_pass, m_fv, m_err[3:0]}, 32'd0);
    cycles = 0;
    while (!m_done && cycles < 3000) begin
      @(posedge clk);
      cycles++;
      #1;
      start1 = (poke && cycles == 100);
      if (poke && cycles == 101) start1 = 1'b0;
    end
    start1 = 1'b0;
    if (!m_done) check("timeout", 32'd0, 32'd1);
    check("latency", cycles, LAT);
    check("busy_fall", {31'b0, m_busy}, 32'd0);
    check("ops_zero", {23'b0, m_vec}, 32'd0);
    e = sb.pop_front();
    check("err_cnt", m_err, e.err);
    check("pass", {31'b0, m_pass}, {31'b0, e.pass});
    check("fail_valid", {31'b0, m_fv}, {31'b0, e.fv});
    check("fail_vec", {23'b0, m_fa, m_fb, m_fc}, {23'b0, e.fa, e.fb, e.fc});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start1   = 1'b0;
    start4   = 1'b0;
    mode     = 0;
    sel      = 1'b0;
    #2;
    check("reset_outs", {a1, b1, cin1, busy1, done1, pass1, err1, fv1, fa1, fb1, fc1}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_wait", {30'b0, busy1, done1}, 32'd0);

    run_sweep(1'b0, 0, 1'b0);   // correct adder
    run_sweep(1'b0, 1, 1'b0);   // s[0] stuck-at-0
    run_sweep(1'b0, 2, 1'b0);   // cout stuck-at-0
    run_sweep(1'b0, 0, 1'b0);   // restart from a failing DONE
    run_sweep(1'b1, 3, 1'b0);   // saturating narrow counter
    run_sweep(1'b0, 0, 1'b1);   // start pulse while busy is ignored

    // Abort a failing sweep at cycle 300 with an off-edge reset.
    sel  = 1'b0;
    mode = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    check("mid_busy", {31'b0, busy1}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {a1, b1, cin1, busy1, done1, pass1, err1, fv1, fa1, fb1, fc1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_idle", {30'b0, busy1, done1}, 32'd0);
    run_sweep(1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
